mul_share_arbiter: RTL
======================

# mul_share_arbiter

Round-robin arbiter that shares one pipelined unsigned `multiplier` between `N_REQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The block registers the granted pair into the shared multiplier and tracks an id tag alongside it. It returns each product to the originating requester a fixed number of cycles later. It sits between the datapath clients and the single multiplier instance so that only one multiplier array is needed.

## Interface
- `DATAWIDTH`, 14: operand width; product width is 2*DATAWIDTH.
- `N_REQ`, 4: number of requesters, ≥2.
- `MUL_LATENCY`, 1: clock cycles from multiplier input to `product`; must match the instantiated multiplier.
- `IDW`, $clog2(N_REQ): requester id width.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req_valid`  input  N_REQ  per-requester operand pair valid.
- `req_ready`  output  N_REQ  one-hot grant; a transfer occurs when valid&ready.
- `req_a`  input  N_REQ*DATAWIDTH  flattened multiplicands; requester i is at [i*DATAWIDTH +: DATAWIDTH].
- `req_b`  input  N_REQ*DATAWIDTH  flattened multipliers, same packing as `req_a`.
- `rsp_valid`  output  N_REQ  one-hot, one-cycle pulse marking the destination of `rsp_product`.
- `rsp_id`  output  IDW  id of the current response.
- `rsp_product`  output  2*DATAWIDTH  unsigned product a*b.
- `busy`  output  1  high while any accepted pair is still in flight.
- `grant_cnt`  output  N_REQ*16  per-requester grant counters (see Configuration).

## Operation
- Arbitration is combinational from `req_valid` and the registered pointer `rr_ptr`. It grants the first valid requester at or after `rr_ptr`, in cyclic order. At most one bit of `req_ready` is high. `req_ready` is 0 for non-valid requesters.
- After a grant to requester g, `rr_ptr` becomes (g+1) mod N_REQ. If nothing is granted, `rr_ptr` holds.
- Requesters hold `req_valid` and their operands stable until accepted. Withdrawing a request before it is accepted is a protocol violation; the behaviour is undefined.
- On acceptance, the operands are registered into the multiplier input registers `mul_a`/`mul_b`. The tag {1, g} enters a tag shift register of depth MUL_LATENCY+1. Idle cycles shift in {0, x}.
- When the tag leaves the shift register with valid=1, the block drives:
  - `rsp_valid[id]`=1;
  - `rsp_id`=id;
  - `rsp_product`=product.
- Responses have no backpressure. The consumer must take every response in the cycle it appears.
- Throughput is one operation per cycle in aggregate. Results return strictly in acceptance order.
- When idle, `mul_a`/`mul_b` hold their previous values; `rsp_product` is don't-care while `rsp_valid` is 0.
- `busy` is the OR of the tag-valid bits.

## Timing
- Reset values:
  - `rsp_valid`=0;
  - `rsp_id`=0;
  - `rsp_product`=0;
  - `busy`=0;
  - `rr_ptr`=0;
  - all tag-valid bits 0;
  - `mul_a`=`mul_b`=0;
  - `grant_cnt`=0.
- Latency from acceptance edge to response: exactly MUL_LATENCY+1 cycles. With the default, a request accepted at edge k produces `rsp_valid` high after edge k+2.
- `req_ready` may only depend on `req_valid` and registered state, never on `req_a`/`req_b`.
- Reset asserted mid-operation: every in-flight tag is cleared and those results are never reported. The first acceptance after reset goes to the lowest-indexed valid requester.
- All requesters valid continuously: grants rotate 0,1,…,N_REQ-1,0 with no idle cycle.

## Configuration
- `MUL_SHARE_STATS_EN` defined:
  - each `grant_cnt` lane is a 16-bit counter of accepted transfers for that requester;
  - counters saturate at 0xFFFF and clear only on reset.
- `MUL_SHARE_STATS_EN` undefined: no counter logic is built and `grant_cnt` is tied to 0.

## Structure
- Shared package `mul_share_pkg`:
  - `CNT_W`=16;
  - a typedef for the tag struct {valid, id};
  - the function computing next `rr_ptr`.
- The block instantiates the existing `multiplier` for the datapath. The one new sub-module is `mul_rr_arbiter`:
  - inputs `req_valid` and `rr_ptr`;
  - outputs the one-hot grant, the encoded id, and any-grant.
- The tag pipeline, counters and response routing stay in the top module.

## Test plan
- Single request, requester 2, a=0xFF, b=0x04 → `req_ready`=0b0100 in the same cycle. Two cycles later, `rsp_valid`=0b0100, `rsp_id`=2, `rsp_product`=0x3FC for exactly one cycle. `busy` is high for two cycles.
- All four requesters valid for 8 cycles, operands a=i+1, b=0x10 → grants in order 0,1,2,3,0,1,2,3. Products are 0x10, 0x20, 0x30, 0x40, repeating, in the same order.
- Maximum operands 0x3FFF*0x3FFF → `rsp_product`=0xFFF8001; 0*0x3FFF → 0.
- Requesters 1 and 3 valid with `rr_ptr`=2 → 3 is granted first, then 1, then 3. Requester 1 holds its operands stable while waiting.
- Reset pulsed while 2 requests are in flight → no `rsp_valid` afterwards. `busy`=0 immediately. The next grant goes to the lowest valid index.
- With `MUL_SHARE_STATS_EN` defined, 5 accepts on requester 0 → `grant_cnt[15:0]`=5 and the other lanes are 0. With the macro undefined, all lanes read 0.

Source files
------------

// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types, constants and pointer helper for mul_share_arbiter
package mul_share_pkg;

    // Width of each per-requester grant counter lane.
    localparam int CNT_W   = 16;
    // Fixed id field width inside the tag; wide enough for any practical N_REQ.
    localparam int TAG_IDW = 8;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    // Round-robin pointer after a grant to g among n requesters: (g+1) mod n.
    function automatic logic [TAG_IDW-1:0] next_rr_ptr(input logic [TAG_IDW-1:0] g,
                                                       input logic [TAG_IDW-1:0] n);
        return (g == n - TAG_IDW'(1)) ? '0 : g + TAG_IDW'(1);
    endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
// Ports: req_valid (per requester), rr_ptr (search start), grant (one-hot),
//        grant_id (encoded grant), any_grant.
module mul_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             any_grant
);

    int             idx_int;
    logic [IDW-1:0] idx;

    // Scan cyclically from rr_ptr; the first valid requester found wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx_int   = 0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx_int = (int'(rr_ptr) + off) % N_REQ;
            idx     = IDW'(idx_int);
            if (!any_grant && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - pipelined unsigned multiplier, LATENCY register stages
// Ports: clk, rst_n (async active-low), a/b operands, product = a*b after LATENCY cycles.
module multiplier #(
    parameter int DW      = 14,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] product
);

    logic [2*DW-1:0] pipe [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= (2*DW)'(a) * (2*DW)'(b);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign product = pipe[LATENCY-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one pipelined multiplier among N_REQ requesters
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b request side;
//        rsp_valid/rsp_id/rsp_product response side; busy; grant_cnt statistics.
// Optional: define MUL_SHARE_STATS_EN to build saturating per-requester grant counters.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int DATAWIDTH   = 14,
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 1,
    parameter int IDW         = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATAWIDTH-1:0] req_a,
    input  logic [N_REQ*DATAWIDTH-1:0] req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [2*DATAWIDTH-1:0]     rsp_product,
    output logic                       busy,
    output logic [N_REQ*CNT_W-1:0]     grant_cnt
);

    logic [IDW-1:0]         rr_ptr;
    logic [N_REQ-1:0]       grant;
    logic [IDW-1:0]         grant_id;
    logic                   any_grant;
    logic [DATAWIDTH-1:0]   mul_a;
    logic [DATAWIDTH-1:0]   mul_b;
    logic [2*DATAWIDTH-1:0] product;
    tag_t                   tag_sr [MUL_LATENCY+1];
    tag_t                   tag_out;

    mul_rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    // Operand capture and pointer advance on acceptance; operands hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else if (any_grant) begin
            rr_ptr <= IDW'(next_rr_ptr(TAG_IDW'(grant_id), TAG_IDW'(N_REQ)));
            mul_a  <= req_a[grant_id*DATAWIDTH +: DATAWIDTH];
            mul_b  <= req_b[grant_id*DATAWIDTH +: DATAWIDTH];
        end
    end

    multiplier #(.DW(DATAWIDTH), .LATENCY(MUL_LATENCY)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (mul_a),
        .b       (mul_b),
        .product (product)
    );

    // Stage 0 lines up with mul_a/mul_b; the last stage lines up with product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MUL_LATENCY; i++) tag_sr[i] <= '0;
        end else begin
            tag_sr[0] <= {any_grant, TAG_IDW'(grant_id)};
            for (int i = 1; i <= MUL_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
        end
    end

    assign tag_out = tag_sr[MUL_LATENCY];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= MUL_LATENCY; i++) busy = busy | tag_sr[i].valid;
    end

    // Response register: routes the product back to its requester as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            rsp_valid   <= '0;
            rsp_product <= product;
            if (tag_out.valid) begin
                rsp_valid[tag_out.id[IDW-1:0]] <= 1'b1;
                rsp_id                         <= tag_out.id[IDW-1:0];
            end
        end
    end

`ifdef MUL_SHARE_STATS_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule
